// File: rtl/bus_arbiter.sv
// bus_arbiter: 8237/8088 hold handshake with bus turnaround and DMA address composition.
// Optional grant-length limit is enabled by defining BUS_ARB_TENURE_EN.
module bus_arbiter #(
  parameter int TURNAROUND = 2,
  parameter int MAX_TENURE = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_hrq,
  input  logic        cpu_hlda,
  output logic        cpu_hold,
  output logic        dma_hlda,
  output logic        dma_aen,
  input  logic        dma_adstb,
  input  logic [7:0]  dma_db,
  input  logic [7:0]  dma_a_lo,
  input  logic [3:0]  dma_dack,
  input  logic        pg_wr,
  input  logic [1:0]  pg_sel,
  input  logic [3:0]  pg_data,
  output logic [19:0] dma_addr,
  output logic        tenure_err
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HOLD_REQ   = 3'd1;
  localparam logic [2:0] S_SETTLE_IN  = 3'd2;
  localparam logic [2:0] S_GRANT      = 3'd3;
  localparam logic [2:0] S_SETTLE_OUT = 3'd4;
  localparam logic [2:0] S_RETURN     = 3'd5;

  localparam logic [3:0] TA_LAST = 4'(TURNAROUND - 1);

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_hi;
  logic [3:0] r_page [4];
  logic [3:0] w_page;
  logic       w_ten_hit;
  logic       w_go;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go)
            r_state <= S_HOLD_REQ;
        end
        S_HOLD_REQ: begin
          if (cpu_hlda) begin
            r_state <= S_SETTLE_IN;
            r_cnt   <= '0;
          end else if (!dma_hrq) begin
            r_state <= S_RETURN;
          end
        end
        S_SETTLE_IN: begin
          if (r_cnt == TA_LAST)
            r_state <= S_GRANT;
          else
            r_cnt <= r_cnt + 4'd1;
        end
        S_GRANT: begin
          if (!dma_hrq || w_ten_hit) begin
            r_state <= S_SETTLE_OUT;
            r_cnt   <= '0;
          end
        end
        S_SETTLE_OUT: begin
          if (r_cnt == TA_LAST)
            r_state <= S_RETURN;
          else
            r_cnt <= r_cnt + 4'd1;
        end
        S_RETURN: begin
          if (!cpu_hlda)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // GRANT is only reachable through a sampled cpu_hlda, so outputs decode state alone
  assign cpu_hold = (r_state == S_HOLD_REQ) || (r_state == S_SETTLE_IN) ||
                    (r_state == S_GRANT) || (r_state == S_SETTLE_OUT);
  assign dma_aen  = (r_state == S_SETTLE_IN) || (r_state == S_GRANT) ||
                    (r_state == S_SETTLE_OUT);
  assign dma_hlda = (r_state == S_GRANT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi <= '0;
      for (int i = 0; i < 4; i++)
        r_page[i] <= '0;
    end else begin
      if (r_state == S_GRANT && dma_adstb)
        r_hi <= dma_db;
      if (pg_wr)
        r_page[pg_sel] <= pg_data;
    end
  end

  always_comb begin
    w_page = r_page[0];
    if (dma_dack[0])
      w_page = r_page[0];
    else if (dma_dack[1])
      w_page = r_page[1];
    else if (dma_dack[2])
      w_page = r_page[2];
    else if (dma_dack[3])
      w_page = r_page[3];
  end

  assign dma_addr = {w_page, r_hi, dma_a_lo};

`ifdef BUS_ARB_TENURE_EN
  logic [15:0] r_ten;
  logic        r_block;
  logic        r_err;

  assign w_ten_hit  = (r_ten == 16'(MAX_TENURE - 1));
  assign w_go       = dma_hrq && !r_block;
  assign tenure_err = r_err;

  // a forced release holds off re-arbitration until the request is withdrawn
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ten   <= '0;
      r_block <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_GRANT)
        r_ten <= r_ten + 16'd1;
      else
        r_ten <= '0;
      if (r_state == S_GRANT && dma_hrq && w_ten_hit) begin
        r_err   <= 1'b1;
        r_block <= 1'b1;
      end else if (!dma_hrq) begin
        r_block <= 1'b0;
      end
    end
  end
`else
  assign w_ten_hit  = 1'b0;
  assign w_go       = dma_hrq;
  // MAX_TENURE is never 0, so this is a constant 0
  assign tenure_err = (MAX_TENURE == 0);
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of the hold handshake, addressing and reset.
// Tenure-limit checks follow BUS_ARB_TENURE_EN.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_hrq = 1'b0;
  logic        cpu_hlda = 1'b0;
  logic        dma_adstb = 1'b0;
  logic [7:0]  dma_db = '0;
  logic [7:0]  dma_a_lo = '0;
  logic [3:0]  dma_dack = '0;
  logic        pg_wr = 1'b0;
  logic [1:0]  pg_sel = '0;
  logic [3:0]  pg_data = '0;
  logic        cpu_hold;
  logic        dma_hlda;
  logic        dma_aen;
  logic [19:0] dma_addr;
  logic        tenure_err;

  int checks = 0;
  int errors = 0;
  int n;

  bus_arbiter #(
    .TURNAROUND(2),
    .MAX_TENURE(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dma_hrq(dma_hrq),
    .cpu_hlda(cpu_hlda),
    .cpu_hold(cpu_hold),
    .dma_hlda(dma_hlda),
    .dma_aen(dma_aen),
    .dma_adstb(dma_adstb),
    .dma_db(dma_db),
    .dma_a_lo(dma_a_lo),
    .dma_dack(dma_dack),
    .pg_wr(pg_wr),
    .pg_sel(pg_sel),
    .pg_data(pg_data),
    .dma_addr(dma_addr),
    .tenure_err(tenure_err)
  );

  always #5 clk = ~clk;

  task automatic step(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic h, input logic a,
                     input logic g);
    chk({tag, ".hold"}, {31'b0, cpu_hold}, {31'b0, h});
    chk({tag, ".aen"}, {31'b0, dma_aen}, {31'b0, a});
    chk({tag, ".hlda"}, {31'b0, dma_hlda}, {31'b0, g});
  endtask

  initial begin
    step(2);
    bus("reset", 0, 0, 0);
    chk("reset.err", {31'b0, tenure_err}, 0);
    chk("reset.addr", {12'b0, dma_addr}, 0);
    rst_n = 1'b1;

    dma_hrq = 1'b1;
    step; bus("hold_req", 1, 0, 0);
    step; bus("wait1", 1, 0, 0);
    step; bus("wait2", 1, 0, 0);
    cpu_hlda = 1'b1;
    step; bus("settle_in1", 1, 1, 0);
    step; bus("settle_in2", 1, 1, 0);
    step; bus("grant", 1, 1, 1);

    pg_wr = 1'b1; pg_sel = 2'd2; pg_data = 4'hA;
    dma_adstb = 1'b1; dma_db = 8'h5C;
    dma_dack = 4'b0100; dma_a_lo = 8'h31;
    #1;
    chk("addr_before_wr", {12'b0, dma_addr}, 32'h00031);
    step;
    pg_wr = 1'b0; dma_adstb = 1'b0;
    chk("addr_comp", {12'b0, dma_addr}, 32'hA5C31);

    dma_hrq = 1'b0;
    step; bus("settle_out1", 1, 1, 0);
    step; bus("settle_out2", 1, 1, 0);
    dma_hrq = 1'b1;
    step; bus("return", 0, 0, 0);
    step; bus("return_wait", 0, 0, 0);
    cpu_hlda = 1'b0;
    step; bus("idle_reentry", 0, 0, 0);
    step; bus("rereq", 1, 0, 0);
    dma_hrq = 1'b0;
    step; bus("abort_ret", 0, 0, 0);
    step; bus("abort_idle", 0, 0, 0);

    dma_adstb = 1'b1; dma_db = 8'hFF;
    step;
    dma_adstb = 1'b0;
    chk("adstb_ignored", {12'b0, dma_addr}, 32'hA5C31);
    pg_wr = 1'b1; pg_sel = 2'd1; pg_data = 4'h3;
    step;
    pg_sel = 2'd3; pg_data = 4'h7;
    step;
    pg_wr = 1'b0;
    dma_dack = 4'b0110; #1;
    chk("dack_lowest", {12'b0, dma_addr}, 32'h35C31);
    dma_dack = 4'b0000; #1;
    chk("dack_none", {12'b0, dma_addr}, 32'h05C31);
    dma_dack = 4'b1000; #1;
    chk("dack3", {12'b0, dma_addr}, 32'h75C31);
    dma_dack = 4'b1111; #1;
    chk("dack_all", {12'b0, dma_addr}, 32'h05C31);

    dma_dack = 4'b0100;
    cpu_hlda = 1'b1;
    dma_hrq = 1'b1;
    step(4); bus("grant2", 1, 1, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (dma_hlda) n++;
      step;
    end
`ifdef BUS_ARB_TENURE_EN
    chk("tenure_len", n, 8);
    chk("tenure_err", {31'b0, tenure_err}, 1);
    bus("forced_ret", 0, 0, 0);
    cpu_hlda = 1'b0;
    step; bus("blocked1", 0, 0, 0);
    step(2); bus("blocked2", 0, 0, 0);
    dma_hrq = 1'b0;
    step;
    dma_hrq = 1'b1;
    step; bus("regrant_req", 1, 0, 0);
    cpu_hlda = 1'b1;
    step(3); bus("grant3", 1, 1, 1);
    chk("err_sticky", {31'b0, tenure_err}, 1);
`else
    chk("unbounded", n, 20);
    bus("still_grant", 1, 1, 1);
    chk("no_tenure_err", {31'b0, tenure_err}, 0);
`endif

    rst_n = 1'b0;
    step; bus("mid_rst", 0, 0, 0);
    chk("mid_rst.addr_hi", {20'b0, dma_addr[19:8]}, 0);
    chk("mid_rst.err", {31'b0, tenure_err}, 0);
    rst_n = 1'b1;
    step; bus("post_rst", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TURNAROUND, default 2, idle cycles with both masters off the bus on each ownership change (1..15).
REQ-002 SHALL have parameter MAX_TENURE, default 256, maximum DMA grant cycles (used only with BUS_ARB_TENURE_EN; 1..65535).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, a synchronous, active-low reset.
REQ-005 SHALL have port dma_hrq, input, 1, the 8237 hold request.
REQ-006 SHALL have port cpu_hlda, input, 1, the 8088 hold acknowledge.
REQ-007 SHALL have port cpu_hold, output, 1, the hold request to the 8088.
REQ-008 SHALL have port dma_hlda, output, 1, the hold acknowledge to the 8237.
REQ-009 SHALL have port dma_aen, output, 1, the bus-owner select to system_bus; 1 means the DMA side owns the bus.
REQ-010 SHALL have port dma_adstb, input, 1, the 8237 address strobe.
REQ-011 SHALL have port dma_db, input, 8, the 8237 data bus carrying A15..A8 during adstb.
REQ-012 SHALL have port dma_a_lo, input, 8, the 8237 A7..A0.
REQ-013 SHALL have port dma_dack, input, 4, the 8237 channel acknowledges, active-high, one-hot.
REQ-014 SHALL have port pg_wr, input, 1, a page-register write strobe from CPU IO decode.
REQ-015 SHALL have port pg_sel, input, 2, the page-register index.
REQ-016 SHALL have port pg_data, input, 4, the page value (A19..A16).
REQ-017 SHALL have port dma_addr, output, 20, the composed DMA address {page, hi, lo}.
REQ-018 SHALL have port tenure_err, output, 1, a sticky flag set when a grant was forcibly ended.

Function
REQ-019 SHALL implement FSM states IDLE, HOLD_REQ, SETTLE_IN, GRANT, SETTLE_OUT, RETURN.
REQ-020 SHALL, in IDLE, drive cpu_hold=0, dma_hlda=0, dma_aen=0, and on dma_hrq=1 go to HOLD_REQ next cycle.
REQ-021 SHALL, in HOLD_REQ, drive cpu_hold=1; on cpu_hlda=1 go to SETTLE_IN; if dma_hrq=0 first, go to RETURN.
REQ-022 SHALL, in SETTLE_IN, drive cpu_hold=1, dma_aen=1, dma_hlda=0 for exactly TURNAROUND cycles, then go to GRANT.
REQ-023 SHALL, in GRANT, drive cpu_hold=1, dma_aen=1, dma_hlda=1; on dma_hrq=0 go to SETTLE_OUT.
REQ-024 SHALL, in SETTLE_OUT, drive dma_hlda=0, dma_aen=1, cpu_hold=1 for exactly TURNAROUND cycles, then go to RETURN.
REQ-025 SHALL, in RETURN, drive cpu_hold=0, dma_aen=0, and go to IDLE only when cpu_hlda=0.
REQ-026 SHALL assert dma_hlda=1 only in GRANT, and only when cpu_hlda has been sampled 1 since HOLD_REQ.
REQ-027 SHALL ensure dma_aen and dma_hlda never rise in the same cycle cpu_hlda is first seen.
REQ-028 SHALL, in GRANT, load the hi-address register from dma_db on each cycle dma_adstb=1; dma_adstb outside GRANT is ignored.
REQ-029 SHALL hold four 4-bit page registers written on pg_wr=1 at index pg_sel, in any state.
REQ-030 SHALL select the page with the lowest set dma_dack bit, or page 0 if no dack bit is set.
REQ-031 SHALL compose dma_addr combinationally from the page, hi register and dma_a_lo.
REQ-032 SHALL apply the new value on the cycle after a simultaneous pg_wr and read of the same page.
REQ-033 SHALL treat dma_hrq as 0 only on an IDLE re-entry, so back-to-back requests re-enter HOLD_REQ one cycle after IDLE.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, force state IDLE, cpu_hold=0, dma_hlda=0, dma_aen=0, hi register 0x00, all page registers 0x0, tenure_err=0, and all counters 0.
REQ-035 SHALL, on a mid-grant reset, have all outputs at reset values on the first edge with rst_n=0.

Configuration
REQ-036 SHALL, with BUS_ARB_TENURE_EN defined, count GRANT cycles and, on reaching MAX_TENURE, go to SETTLE_OUT and set tenure_err (cleared only by reset).
REQ-037 SHALL, with BUS_ARB_TENURE_EN defined, refuse to leave IDLE after a forced release until dma_hrq has been sampled 0 for at least one cycle.
REQ-038 SHALL, without BUS_ARB_TENURE_EN, have no tenure counter, hold tenure_err constantly 0, and keep the grant length unbounded.

Verification
REQ-039 SHALL cover a basic handshake: hrq=1, hlda returned 3 cycles after hold -> aen=1 the cycle after hlda, dma_hlda=1 after 2 more cycles; hrq=0 -> dma_hlda=0 next cycle, aen=0 after 2 cycles, then hold=0.
REQ-040 SHALL cover an aborted request: hrq pulses 1 cycle, hlda never arrives -> hold=1 for 1 cycle, RETURN, IDLE; dma_hlda and aen stay 0.
REQ-041 SHALL cover address composition: pg_wr sel=2 data=0xA, dack=0100, adstb with db=0x5C, a_lo=0x31 -> dma_addr=0xA5C31.
REQ-042 SHALL cover a tenure limit: MAX_TENURE=8, hrq held high -> dma_hlda high exactly 8 cycles, tenure_err=1, no re-grant until hrq drops for 1 cycle.
REQ-043 SHALL cover reset mid-grant: rst_n=0 during GRANT -> next edge: hold=0, dma_hlda=0, aen=0, dma_addr upper 12 bits = 0.
